cache_fill_wordline_ctrl: RTL and testbench
===========================================

// Module: cache_fill_wordline_ctrl
// PURPOSE
//  Parametrised successor to the fixed 7->128 cache wordline decoder. Decodes a
//  set index to a one-hot line wordline and a one-hot word select. Sequences
//  multi-beat block fills from memory and sweeps all lines on flush.
//  Maintains the per-line valid bits. Sits between the cache controller FSM
//  and the data/tag/valid arrays.
// PARAMETERS
//  IDX_W   7            set-index width
//  LINES   1<<IDX_W     number of lines (wordline width)
//  WSEL_W  3            word-in-block index width
//  WORDS   1<<WSEL_W    words per block (wordsel width)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  wr_en       in   1       single-word write request (hit store)
//  wr_idx      in   IDX_W   line index for wr_en
//  wr_word     in   WSEL_W  word index for wr_en
//  fill_start  in   1       begin block fill of fill_idx
//  fill_idx    in   IDX_W   line to fill, sampled on accepted fill_start
//  mem_valid   in   1       memory data beat present this cycle
//  flush       in   1       invalidate all lines (sweep)
//  wordline    out  LINES   one-hot line write enable, else all-zero
//  wordsel     out  WORDS   one-hot word write enable, else all-zero
//  tag_we      out  1       write tag/valid of the wordline line this cycle
//  valid       out  LINES   per-line valid bits (registered)
//  busy        out  1       state != IDLE
//  fill_done   out  1       1-cycle pulse after last fill beat
//  flush_done  out  1       1-cycle pulse after last line swept
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; beat=0; sweep=0; valid=0; fill_done=flush_done=0.
//   - An in-progress fill aborts and its line is left invalid.
//  States: IDLE, FILL, FLUSH.
//  IDLE, priority flush > fill_start > wr_en:
//   - flush: -> FLUSH, sweep=0.
//   - fill_start: latch fill_idx, beat=0, clear valid[fill_idx] at this edge, -> FILL.
//   - wr_en alone: same cycle (combinational) wordline=1<<wr_idx,
//     wordsel=1<<wr_word, tag_we=0. No state change.
//  FILL:
//   - wordline=1<<idx_q and wordsel=1<<beat only while mem_valid=1; else both 0.
//   - Each mem_valid beat: beat+=1.
//   - Beat WORDS-1 with mem_valid: tag_we=1 that cycle; at the edge valid[idx_q]=1,
//     beat wraps to 0, -> IDLE. fill_done=1 in the following cycle.
//   - wr_en, fill_start and flush are ignored (controller must hold them).
//  FLUSH:
//   - Each cycle: wordline=1<<sweep, wordsel=0, tag_we=1, valid[sweep] cleared.
//   - sweep increments each cycle. At sweep=LINES-1: -> IDLE, sweep wraps to 0,
//     flush_done=1 in the next cycle. Sweep takes exactly LINES cycles.
//  Outputs:
//   - wordline/wordsel/tag_we are combinational from state+inputs, zero-latency.
//   - At most one wordline bit is set in any cycle.
//   - wordline=0 whenever rst=1.
//   - valid/busy/done pulses are registered.
//  Arithmetic:
//   - beat is WSEL_W bits, sweep is IDX_W bits; both wrap naturally.
//   - Decode is shift-based (1<<n), sized to LINES/WORDS.
//   - No out-of-range index exists (LINES=2^IDX_W).
// STRUCTURE
//  - Shared package cache_pkg: IDX_W, WSEL_W defaults; state enum
//    {IDLE,FILL,FLUSH}.
//  - Sub-module onehot_decoder #(N) (en, sel -> one-hot), instanced twice
//    (line, word). Replaces the hand-enumerated decoder.
// TESTING
//  1. wr_en=1, wr_idx=5, wr_word=2 in IDLE -> wordline=bit5 only, wordsel=4'h4
//     same cycle, valid unchanged.
//  2. fill_start, idx=127; 8 mem_valid beats with gaps -> wordsel walks 1..0x80
//     on valid beats only. tag_we on beat 7. valid[127]=1 next edge.
//     fill_done pulses once.
//  3. flush with several valid lines -> 128 cycles of wordline 1<<0..1<<127,
//     tag_we=1. valid=0 after. flush_done pulse at cycle 129.
//  4. flush+fill_start+wr_en same cycle in IDLE -> FLUSH taken; no fill, no
//     write wordline.
//  5. rst asserted after beat 3 of fill on line 9 -> outputs zero immediately.
//     valid[9]=0, busy=0. A new fill starts cleanly at beat 0.
//  6. IDX_W=4, WSEL_W=2 build -> 16-line sweep, 4-beat fill. The one-hot
//     invariant holds every cycle (assertion).

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared parameters and state type for the cache wordline controller
package cache_pkg;

  localparam int IDX_W  = 7;
  localparam int WSEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/cache_fill_wordline_ctrl_if.sv
// rtl/cache_fill_wordline_ctrl_if.sv - controller <-> wordline block signal bundle
// master: cache controller side (drives requests, observes enables/status)
// slave : wordline controller side
//   requests : wr_en, wr_idx, wr_word, fill_start, fill_idx, mem_valid, flush
//   enables  : wordline, wordsel, tag_we
//   status   : valid, busy, fill_done, flush_done
interface cache_fill_wordline_ctrl_if #(
  parameter int IDX_W  = cache_pkg::IDX_W,
  parameter int WSEL_W = cache_pkg::WSEL_W
);
  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << WSEL_W;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [WSEL_W-1:0] wr_word;
  logic              fill_start;
  logic [IDX_W-1:0]  fill_idx;
  logic              mem_valid;
  logic              flush;
  logic [LINES-1:0]  wordline;
  logic [WORDS-1:0]  wordsel;
  logic              tag_we;
  logic [LINES-1:0]  valid;
  logic              busy;
  logic              fill_done;
  logic              flush_done;

  modport master (
    output wr_en, wr_idx, wr_word, fill_start, fill_idx, mem_valid, flush,
    input  wordline, wordsel, tag_we, valid, busy, fill_done, flush_done
  );

  modport slave (
    input  wr_en, wr_idx, wr_word, fill_start, fill_idx, mem_valid, flush,
    output wordline, wordsel, tag_we, valid, busy, fill_done, flush_done
  );

endinterface

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - enable-gated shift decoder, sel -> one-hot of width N
// en_i     : when low the output is all-zero
// sel_i    : bit position to set
// onehot_o : 1 << sel_i, or zero
module onehot_decoder #(
  parameter int N     = 128,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N-1:0]     onehot_o
);

  localparam logic [N-1:0] ONE = N'(1);

  assign onehot_o = en_i ? (ONE << sel_i) : '0;

endmodule

// File: rtl/cache_fill_wordline_ctrl.sv
// rtl/cache_fill_wordline_ctrl.sv - wordline/wordsel decode, block fill sequencing, flush sweep, valid bits
// clk : rising-edge clock
// rst : asynchronous active-high reset
// bus : slave side of cache_fill_wordline_ctrl_if (requests in, enables/status out)
module cache_fill_wordline_ctrl #(
  parameter int IDX_W  = cache_pkg::IDX_W,
  parameter int WSEL_W = cache_pkg::WSEL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  cache_fill_wordline_ctrl_if.slave bus
);
  import cache_pkg::*;

  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << WSEL_W;

  state_e            state_q, state_d;
  logic [WSEL_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              fill_done_q, fill_done_d;
  logic              flush_done_q, flush_done_d;

  logic              line_en, word_en, tag_we;
  logic [IDX_W-1:0]  line_sel;
  logic [WSEL_W-1:0] word_sel;
  logic [LINES-1:0]  wordline;
  logic [WORDS-1:0]  wordsel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      sweep_q      <= '0;
      idx_q        <= '0;
      valid_q      <= '0;
      fill_done_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      sweep_q      <= sweep_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      fill_done_q  <= fill_done_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    sweep_d      = sweep_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    fill_done_d  = 1'b0;
    flush_done_d = 1'b0;
    line_en      = 1'b0;
    line_sel     = idx_q;
    word_en      = 1'b0;
    word_sel     = beat_q;
    tag_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          sweep_d = '0;
          state_d = FLUSH;
        end else if (bus.fill_start) begin
          // Line goes invalid now so a fill aborted by reset never leaves stale data marked valid.
          idx_d                 = bus.fill_idx;
          beat_d                = '0;
          valid_d[bus.fill_idx] = 1'b0;
          state_d               = FILL;
        end else if (bus.wr_en) begin
          line_en  = 1'b1;
          line_sel = bus.wr_idx;
          word_en  = 1'b1;
          word_sel = bus.wr_word;
        end
      end

      FILL: begin
        if (bus.mem_valid) begin
          line_en = 1'b1;
          word_en = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (&beat_q) begin
            tag_we         = 1'b1;
            valid_d[idx_q] = 1'b1;
            fill_done_d    = 1'b1;
            state_d        = IDLE;
          end
        end
      end

      FLUSH: begin
        line_en          = 1'b1;
        line_sel         = sweep_q;
        tag_we           = 1'b1;
        valid_d[sweep_q] = 1'b0;
        sweep_d          = sweep_q + 1'b1;
        if (&sweep_q) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Gating the enables with rst keeps the arrays untouched for the whole reset pulse.
  onehot_decoder #(.N(LINES), .SEL_W(IDX_W)) u_line_dec (
    .en_i     (line_en & ~rst),
    .sel_i    (line_sel),
    .onehot_o (wordline)
  );

  onehot_decoder #(.N(WORDS), .SEL_W(WSEL_W)) u_word_dec (
    .en_i     (word_en & ~rst),
    .sel_i    (word_sel),
    .onehot_o (wordsel)
  );

  assign bus.wordline   = wordline;
  assign bus.wordsel    = wordsel;
  assign bus.tag_we     = tag_we & ~rst;
  assign bus.valid      = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.fill_done  = fill_done_q;
  assign bus.flush_done = flush_done_q;

  a_onehot_wordline : assert property (@(posedge clk) disable iff (rst) $onehot0(wordline));
  a_onehot_wordsel  : assert property (@(posedge clk) disable iff (rst) $onehot0(wordsel));

endmodule

// File: tb/tb_cache_fill_wordline_ctrl.sv
// tb/tb_cache_fill_wordline_ctrl.sv - directed self-checking bench for cache_fill_wordline_ctrl
module tb_cache_fill_wordline_ctrl;

  localparam int LINES   = 128;
  localparam int WORDS   = 8;
  localparam int S_LINES = 16;
  localparam int S_WORDS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_wordline_ctrl_if #(.IDX_W(7), .WSEL_W(3)) b ();
  cache_fill_wordline_ctrl #(.IDX_W(7), .WSEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  cache_fill_wordline_ctrl_if #(.IDX_W(4), .WSEL_W(2)) s ();
  cache_fill_wordline_ctrl #(.IDX_W(4), .WSEL_W(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (s)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    b.wr_en = 0; b.wr_idx = '0; b.wr_word = '0; b.fill_start = 0;
    b.fill_idx = '0; b.mem_valid = 0; b.flush = 0;
    s.wr_en = 0; s.wr_idx = '0; s.wr_word = '0; s.fill_start = 0;
    s.fill_idx = '0; s.mem_valid = 0; s.flush = 0;
  endtask

  // Full fill of one line on the big instance, optionally with an idle gap before each beat.
  task automatic fill_big(input int idx, input bit gaps);
    logic [127:0] one_line;
    one_line = 128'(1) << idx;
    nxt(); b.fill_start = 1; b.fill_idx = 7'(idx); #1;
    expect_eq("fill_req_wl", 128'(b.wordline), '0);
    for (int beat = 0; beat < WORDS; beat++) begin
      if (gaps) begin
        nxt(); b.fill_start = 0; b.mem_valid = 0; #1;
        expect_eq("fill_gap_wl", 128'(b.wordline), '0);
        expect_eq("fill_gap_ws", 128'(b.wordsel), '0);
        expect_eq("fill_gap_busy", 128'(b.busy), 1);
      end
      nxt(); b.fill_start = 0; b.mem_valid = 1; #1;
      expect_eq("fill_wl", 128'(b.wordline), one_line);
      expect_eq("fill_ws", 128'(b.wordsel), 128'(1) << beat);
      expect_eq("fill_tag_we", 128'(b.tag_we), (beat == WORDS - 1) ? 128'd1 : 128'd0);
      expect_eq("fill_done_early", 128'(b.fill_done), 0);
    end
    nxt(); b.mem_valid = 0; #1;
    expect_eq("fill_valid_set", 128'(b.valid[idx]), 1);
    expect_eq("fill_done_pulse", 128'(b.fill_done), 1);
    expect_eq("fill_busy_off", 128'(b.busy), 0);
    nxt(); #1;
    expect_eq("fill_done_clear", 128'(b.fill_done), 0);
  endtask

  // Full flush sweep on the big instance; combo also raises fill_start and wr_en on the request cycle.
  task automatic flush_big(input bit combo);
    nxt(); b.flush = 1;
    if (combo) begin
      b.fill_start = 1; b.fill_idx = 7'd9; b.wr_en = 1; b.wr_idx = 7'd5; b.wr_word = 3'd2;
    end
    #1;
    expect_eq("flush_req_wl", 128'(b.wordline), '0);
    expect_eq("flush_req_ws", 128'(b.wordsel), '0);
    for (int i = 0; i < LINES; i++) begin
      nxt(); idle_inputs(); #1;
      expect_eq("flush_wl", 128'(b.wordline), 128'(1) << i);
      expect_eq("flush_ws", 128'(b.wordsel), '0);
      expect_eq("flush_tag_we", 128'(b.tag_we), 1);
    end
    nxt(); #1;
    expect_eq("flush_valid_zero", 128'(b.valid), '0);
    expect_eq("flush_done_pulse", 128'(b.flush_done), 1);
    expect_eq("flush_busy_off", 128'(b.busy), 0);
    nxt(); #1;
    expect_eq("flush_done_clear", 128'(b.flush_done), 0);
    expect_eq("flush_still_idle", 128'(b.busy), 0);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    b.wr_en = 1; b.wr_idx = 7'd3;
    nxt(); nxt(); #1;
    expect_eq("rst_wordline", 128'(b.wordline), '0);
    expect_eq("rst_valid", 128'(b.valid), '0);
    expect_eq("rst_busy", 128'(b.busy), 0);
    expect_eq("rst_fill_done", 128'(b.fill_done), 0);
    expect_eq("rst_flush_done", 128'(b.flush_done), 0);
    nxt(); rst = 0; idle_inputs();

    // Hit store decode in IDLE
    nxt(); b.wr_en = 1; b.wr_idx = 7'd5; b.wr_word = 3'd2; #1;
    expect_eq("wr_wordline", 128'(b.wordline), 128'(1) << 5);
    expect_eq("wr_wordsel", 128'(b.wordsel), 128'h04);
    expect_eq("wr_tag_we", 128'(b.tag_we), 0);
    nxt(); b.wr_en = 1; b.wr_idx = 7'd127; b.wr_word = 3'd7; #1;
    expect_eq("wr_wordline_top", 128'(b.wordline), 128'(1) << 127);
    expect_eq("wr_wordsel_top", 128'(b.wordsel), 128'h80);
    nxt(); idle_inputs(); #1;
    expect_eq("wr_valid_same", 128'(b.valid), '0);
    expect_eq("wr_busy", 128'(b.busy), 0);

    // Gapped fill of the top line, then a back-to-back fill of line 3
    fill_big(127, 1'b1);
    fill_big(3, 1'b0);
    expect_eq("two_lines_valid", 128'(b.valid), (128'(1) << 127) | (128'(1) << 3));

    flush_big(1'b0);
    flush_big(1'b1);

    // Reset mid-fill on line 9 after beat 3
    nxt(); b.fill_start = 1; b.fill_idx = 7'd9;
    for (int beat = 0; beat < 4; beat++) begin
      nxt(); b.fill_start = 0; b.mem_valid = 1; #1;
      expect_eq("abort_ws", 128'(b.wordsel), 128'(1) << beat);
    end
    nxt(); rst = 1; b.mem_valid = 1; #1;
    expect_eq("abort_wl_zero", 128'(b.wordline), '0);
    expect_eq("abort_ws_zero", 128'(b.wordsel), '0);
    expect_eq("abort_tag_we", 128'(b.tag_we), 0);
    expect_eq("abort_busy", 128'(b.busy), 0);
    nxt(); rst = 0; idle_inputs(); #1;
    expect_eq("abort_valid9", 128'(b.valid[9]), 0);
    expect_eq("abort_busy_after", 128'(b.busy), 0);
    expect_eq("abort_fill_done", 128'(b.fill_done), 0);
    fill_big(9, 1'b0);

    // Small build: 4-beat fill of line 15, 16-line sweep
    nxt(); s.fill_start = 1; s.fill_idx = 4'd15;
    for (int beat = 0; beat < S_WORDS; beat++) begin
      nxt(); s.fill_start = 0; s.mem_valid = 1; #1;
      expect_eq("s_fill_wl", 128'(s.wordline), 128'(1) << 15);
      expect_eq("s_fill_ws", 128'(s.wordsel), 128'(1) << beat);
      expect_eq("s_fill_tag_we", 128'(s.tag_we), (beat == S_WORDS - 1) ? 128'd1 : 128'd0);
    end
    nxt(); s.mem_valid = 0; #1;
    expect_eq("s_fill_valid", 128'(s.valid), 128'h8000);
    expect_eq("s_fill_done", 128'(s.fill_done), 1);
    nxt(); s.flush = 1;
    for (int i = 0; i < S_LINES; i++) begin
      nxt(); s.flush = 0; #1;
      expect_eq("s_flush_wl", 128'(s.wordline), 128'(1) << i);
      expect_eq("s_flush_tag_we", 128'(s.tag_we), 1);
    end
    nxt(); #1;
    expect_eq("s_flush_done", 128'(s.flush_done), 1);
    expect_eq("s_flush_valid", 128'(s.valid), '0);
    expect_eq("s_flush_busy", 128'(s.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
